// File: rtl/ex_mem.sv
// EX/MEM pipeline register with a data-memory handshake.
// Holds a load/store in ACCESS until MemAck, freezing upstream stages.
module ex_mem (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        Branch_in,
    input  logic [31:0] ALUResult_in,
    input  logic        Zero_in,
    input  logic [31:0] BranchTarget_in,
    input  logic [31:0] WriteData_in,
    input  logic [4:0]  WriteReg_in,
    input  logic        Stall_in,
    input  logic        Flush_in,
    input  logic        MemAck,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic [31:0] ALUResult_out,
    output logic [31:0] BranchTarget_out,
    output logic [31:0] WriteData_out,
    output logic [4:0]  WriteReg_out,
    output logic        Valid,
    output logic        MemReq,
    output logic        MemStall,
    output logic        PCSrc
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] target;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic        valid;
    } ex_mem_t;

    state_e  state_q, state_d;
    ex_mem_t ent_q, ent_d, ent_in;
    logic    flush_pend_q, flush_pend_d;
    logic    advance;
    logic    flush;

    always_comb begin
        ent_in            = '0;
        ent_in.reg_write  = RegWrite_in;
        ent_in.mem_to_reg = MemtoReg_in;
        ent_in.mem_read   = MemRead_in;
        ent_in.mem_write  = MemWrite_in;
        ent_in.branch     = Branch_in;
        ent_in.zero       = Zero_in;
        ent_in.alu        = ALUResult_in;
        ent_in.target     = BranchTarget_in;
        ent_in.wdata      = WriteData_in;
        ent_in.wreg       = WriteReg_in;
        ent_in.valid      = 1'b1;
    end

    assign advance = ((state_q == IDLE) || MemAck) && !Stall_in;
    assign flush   = Flush_in || flush_pend_q;

    always_comb begin
        ent_d        = ent_q;
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        if (advance) begin
            flush_pend_d = 1'b0;
            if (flush) begin
                ent_d   = '0;
                state_d = IDLE;
            end else begin
                ent_d   = ent_in;
                state_d = (MemRead_in || MemWrite_in) ? ACCESS : IDLE;
            end
        end else begin
            if (Flush_in)
                flush_pend_d = 1'b1;
            // An ack under downstream stall still retires the access.
            if (state_q == ACCESS && MemAck)
                state_d = IDLE;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= IDLE;
            ent_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ent_q        <= ent_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign RegWrite         = ent_q.reg_write;
    assign MemtoReg         = ent_q.mem_to_reg;
    assign MemRead          = ent_q.mem_read;
    assign MemWrite         = ent_q.mem_write;
    assign Branch           = ent_q.branch;
    assign ALUResult_out    = ent_q.alu;
    assign BranchTarget_out = ent_q.target;
    assign WriteData_out    = ent_q.wdata;
    assign WriteReg_out     = ent_q.wreg;
    assign Valid            = ent_q.valid;
    assign MemReq           = (state_q == ACCESS);
    assign MemStall         = (state_q == ACCESS) && !MemAck;
    assign PCSrc            = ent_q.valid && ent_q.branch && ent_q.zero;

endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for the EX/MEM register and its memory handshake.
// Hand-computed expectations, checked with immediate assertions.
module tb_ex_mem;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, Branch_in;
    logic [31:0] ALUResult_in, BranchTarget_in, WriteData_in;
    logic        Zero_in;
    logic [4:0]  WriteReg_in;
    logic        Stall_in, Flush_in, MemAck;
    logic        RegWrite, MemtoReg, MemRead, MemWrite, Branch;
    logic [31:0] ALUResult_out, BranchTarget_out, WriteData_out;
    logic [4:0]  WriteReg_out;
    logic        Valid, MemReq, MemStall, PCSrc;

    int total = 0;
    int bad   = 0;

    ex_mem dut (
        .Clk(Clk), .Rst(Rst),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .Branch_in(Branch_in), .ALUResult_in(ALUResult_in),
        .Zero_in(Zero_in), .BranchTarget_in(BranchTarget_in),
        .WriteData_in(WriteData_in), .WriteReg_in(WriteReg_in),
        .Stall_in(Stall_in), .Flush_in(Flush_in), .MemAck(MemAck),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemRead(MemRead),
        .MemWrite(MemWrite), .Branch(Branch),
        .ALUResult_out(ALUResult_out),
        .BranchTarget_out(BranchTarget_out),
        .WriteData_out(WriteData_out), .WriteReg_out(WriteReg_out),
        .Valid(Valid), .MemReq(MemReq), .MemStall(MemStall),
        .PCSrc(PCSrc)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        RegWrite_in = 0; MemtoReg_in = 0; MemRead_in = 0;
        MemWrite_in = 0; Branch_in = 0; Zero_in = 0;
        ALUResult_in = 0; BranchTarget_in = 0; WriteData_in = 0;
        WriteReg_in = 0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst = 0; Stall_in = 0; Flush_in = 0; MemAck = 0;
        clr_in();
        #12;
        chk("rst_alu", ALUResult_out, 0);
        chk("rst_valid", {31'b0, Valid}, 0);
        chk("rst_memreq", {31'b0, MemReq}, 0);
        chk("rst_wreg", {27'b0, WriteReg_out}, 0);
        Rst = 1;

        // plain ALU op capture
        ALUResult_in = 32'h10; WriteReg_in = 5; RegWrite_in = 1;
        tick();
        chk("cap_alu", ALUResult_out, 32'h10);
        chk("cap_wreg", {27'b0, WriteReg_out}, 5);
        chk("cap_valid", {31'b0, Valid}, 1);
        chk("cap_regw", {31'b0, RegWrite}, 1);
        chk("cap_memreq", {31'b0, MemReq}, 0);

        // stall two cycles in IDLE
        Stall_in = 1; ALUResult_in = 32'h99; WriteReg_in = 3;
        tick();
        tick();
        chk("stall_alu", ALUResult_out, 32'h10);
        chk("stall_wreg", {27'b0, WriteReg_out}, 5);
        chk("stall_memstall", {31'b0, MemStall}, 0);

        // MemAck in IDLE is ignored while stalled
        MemAck = 1;
        tick();
        chk("idle_ack_alu", ALUResult_out, 32'h10);
        chk("idle_ack_req", {31'b0, MemReq}, 0);
        MemAck = 0; Stall_in = 0;

        // load waits three cycles for ack
        clr_in();
        MemRead_in = 1; MemtoReg_in = 1; RegWrite_in = 1;
        ALUResult_in = 32'h100; WriteReg_in = 7;
        tick();
        clr_in();
        RegWrite_in = 1; ALUResult_in = 32'h200; WriteReg_in = 9;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("ld_req_c%0d", c), {31'b0, MemReq}, 1);
            chk($sformatf("ld_stall_c%0d", c), {31'b0, MemStall}, 1);
            chk($sformatf("ld_alu_c%0d", c), ALUResult_out, 32'h100);
            if (c < 3) tick();
        end
        MemAck = 1;
        #1;
        chk("ld_ack_stall", {31'b0, MemStall}, 0);
        chk("ld_ack_req", {31'b0, MemReq}, 1);
        tick();
        MemAck = 0;
        chk("ld_next_alu", ALUResult_out, 32'h200);
        chk("ld_next_wreg", {27'b0, WriteReg_out}, 9);
        chk("ld_next_memread", {31'b0, MemRead}, 0);
        chk("ld_next_req", {31'b0, MemReq}, 0);

        // flush during ACCESS becomes a bubble on ack
        clr_in();
        MemWrite_in = 1; ALUResult_in = 32'h300;
        WriteData_in = 32'hDEAD_BEEF;
        tick();
        chk("st_wdata", WriteData_out, 32'hDEAD_BEEF);
        chk("st_req", {31'b0, MemReq}, 1);
        clr_in();
        RegWrite_in = 1; ALUResult_in = 32'h400; Flush_in = 1;
        tick();
        Flush_in = 0;
        chk("fl_hold_alu", ALUResult_out, 32'h300);
        chk("fl_hold_req", {31'b0, MemReq}, 1);
        MemAck = 1;
        tick();
        MemAck = 0;
        chk("fl_bub_valid", {31'b0, Valid}, 0);
        chk("fl_bub_regw", {31'b0, RegWrite}, 0);
        chk("fl_bub_memw", {31'b0, MemWrite}, 0);
        chk("fl_bub_alu", ALUResult_out, 0);
        chk("fl_bub_req", {31'b0, MemReq}, 0);
        tick();
        chk("fl_after_alu", ALUResult_out, 32'h400);
        chk("fl_after_valid", {31'b0, Valid}, 1);

        // branch resolution
        clr_in();
        Branch_in = 1; Zero_in = 1; BranchTarget_in = 32'h40;
        tick();
        chk("br_pcsrc", {31'b0, PCSrc}, 1);
        chk("br_target", BranchTarget_out, 32'h40);
        Zero_in = 0;
        tick();
        chk("br_nz_pcsrc", {31'b0, PCSrc}, 0);
        Zero_in = 1; Flush_in = 1;
        tick();
        Flush_in = 0;
        chk("br_fl_pcsrc", {31'b0, PCSrc}, 0);
        chk("br_fl_target", BranchTarget_out, 0);

        // read+write single access, ack under stall
        clr_in();
        MemRead_in = 1; MemWrite_in = 1; ALUResult_in = 32'h600;
        tick();
        chk("rw_req", {31'b0, MemReq}, 1);
        clr_in();
        RegWrite_in = 1; ALUResult_in = 32'h700;
        Stall_in = 1; MemAck = 1;
        tick();
        MemAck = 0;
        chk("sa_req", {31'b0, MemReq}, 0);
        chk("sa_alu", ALUResult_out, 32'h600);
        tick();
        chk("sa2_req", {31'b0, MemReq}, 0);
        chk("sa2_stall", {31'b0, MemStall}, 0);
        chk("sa2_alu", ALUResult_out, 32'h600);
        Stall_in = 0;
        tick();
        chk("sa_next_alu", ALUResult_out, 32'h700);
        chk("sa_next_req", {31'b0, MemReq}, 0);

        // asynchronous reset mid-ACCESS
        clr_in();
        MemRead_in = 1; ALUResult_in = 32'h800; WriteReg_in = 4;
        tick();
        chk("ar_pre_req", {31'b0, MemReq}, 1);
        #2;
        Rst = 0;
        #1;
        chk("ar_req", {31'b0, MemReq}, 0);
        chk("ar_alu", ALUResult_out, 0);
        chk("ar_valid", {31'b0, Valid}, 0);
        chk("ar_memread", {31'b0, MemRead}, 0);
        chk("ar_wreg", {27'b0, WriteReg_out}, 0);
        Rst = 1;
        clr_in();
        RegWrite_in = 1; ALUResult_in = 32'h500;
        tick();
        chk("ar_post_alu", ALUResult_out, 32'h500);
        chk("ar_post_valid", {31'b0, Valid}, 1);
        chk("ar_post_req", {31'b0, MemReq}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: EX_MEM

Interface
REQ-001 Clk  in  1  single rising-edge clock for all state.
REQ-002 Rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, Branch_in  in  1 each  control bits from ID/EX.
REQ-004 ALUResult_in  in  32  ALU result, also the memory address.
REQ-005 Zero_in  in  1  ALU zero flag.
REQ-006 BranchTarget_in  in  32  computed branch target.
REQ-007 WriteData_in  in  32  store data (rt value).
REQ-008 WriteReg_in  in  5  destination register number.
REQ-009 Stall_in  in  1  downstream hold request.
REQ-010 Flush_in  in  1  replace the next capture with a bubble.
REQ-011 MemAck  in  1  data-memory handshake acknowledge.
REQ-012 RegWrite, MemtoReg, MemRead, MemWrite, Branch  out  1 each  registered control bits.
REQ-013 ALUResult_out, BranchTarget_out, WriteData_out  out  32 each  registered data.
REQ-014 WriteReg_out  out  5  registered destination.
REQ-015 Valid  out  1  register holds a real instruction.
REQ-016 MemReq  out  1  data-memory request.
REQ-017 MemStall  out  1  freeze request to IF/ID/EX.
REQ-018 PCSrc  out  1  branch taken.

Function
REQ-019 States: IDLE (no outstanding memory op) and ACCESS (valid load/store awaiting MemAck).
REQ-020 Advance = (state==IDLE or MemAck==1) and Stall_in==0; registers load only on a rising Clk edge with Advance=1, otherwise all registered outputs hold.
REQ-021 On advance with Flush_in=1 or FlushPend=1: every control bit, Valid, and data field loads 0 (bubble); FlushPend clears.
REQ-022 On advance without a flush: all *_in values load and Valid loads 1.
REQ-023 Flush_in=1 in a cycle without advance sets internal FlushPend; FlushPend is held until the next advance.
REQ-024 Next state on advance: ACCESS if the loaded instruction has Valid=1 and (MemRead or MemWrite), else IDLE; without advance the state is held.
REQ-025 MemReq = (state==ACCESS), combinational from state.
REQ-026 MemStall = (state==ACCESS) and MemAck==0, combinational; a same-cycle ack gives zero stall cycles.
REQ-027 PCSrc = Valid and Branch and Zero, from registered values; Zero is registered with the other fields.
REQ-028 Stall_in=1 and MemAck=1 in the same cycle: the transaction completes, state goes IDLE, and the register holds with MemReq=0 afterwards. The access is not reissued.
REQ-029 MemRead=1 and MemWrite=1 in the same instruction are treated as one access (single MemReq).
REQ-030 Latency: one cycle from input to registered output.
REQ-031 MemAck sampled in IDLE is ignored.

Reset
REQ-032 Rst=0 immediately, without a clock edge, forces every output and register to 0, state IDLE, and FlushPend=0.
REQ-033 Reset asserted during ACCESS aborts the access: MemReq drops to 0 combinationally.
REQ-034 After Rst returns to 1, the first rising edge follows REQ-020..024.

Verification
REQ-035 Capture: ALU op ALUResult_in=0x0000_0010, WriteReg_in=5, RegWrite_in=1 -> after one edge, ALUResult_out=0x10, WriteReg_out=5, Valid=1, MemReq=0.
REQ-036 Load with MemAck low for 3 cycles -> MemReq=1 and MemStall=1 for 3 cycles, outputs held; ack in cycle 4 -> MemStall=0 and the next instruction is captured on that edge.
REQ-037 Flush_in=1 during ACCESS -> no change until ack; the captured entry is a bubble (Valid=0, all control 0).
REQ-038 Branch_in=1, Zero_in=1, BranchTarget_in=0x40 -> PCSrc=1 and BranchTarget_out=0x40; the same with Flush_in=1 -> PCSrc=0.
REQ-039 Stall_in=1 for 2 cycles in IDLE -> all outputs unchanged, MemStall=0.
REQ-040 Rst pulled low mid-ACCESS between clock edges -> all outputs 0 and MemReq=0 immediately.
